// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//
// Owns the write port of the 8-bit system LED GPIO register. A small CPU
// register file selects one of four display modes: manual value, blink,
// bouncing scan and binary count. The sequenced modes advance the LED frame
// from a prescaled time base. Every frame load or step produces a one-cycle
// gpio_write pulse in the following cycle, carrying the new frame.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   resetn     synchronous active-low reset
//   cpu_write  register write strobe (one cycle per access)
//   cpu_addr   0 CTRL, 1 PATTERN, 2 RATE, 3 FRAME (read-only)
//   cpu_wdata  write data
//   cpu_read   read strobe
//   cpu_rdata  combinational read data, 0 when cpu_read is low
//   gpio_write registered one-cycle write pulse to the LED register
//   gpio_wdata registered data for the LED register, tracks FRAME
// ---------------------------------------------------------------------------
module led_sequencer #(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cpu_write,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_read,
    output logic [7:0] cpu_rdata,
    output logic       gpio_write,
    output logic [7:0] gpio_wdata
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_RATE    = 2'd2;
    localparam logic [1:0] ADDR_FRAME   = 2'd3;

    // ctrl_reg = {run, mode[1:0]}
    logic [2:0]    ctrl_reg, ctrl_next;
    logic [7:0]    pattern_reg, pattern_next;
    logic [7:0]    rate_reg, rate_next;
    logic [7:0]    frame_reg, frame_next;
    logic          dir_reg, dir_next;          // 0 = shifting up, 1 = down
    logic [PW-1:0] presc_reg, presc_next;
    logic [7:0]    rate_cnt_reg, rate_cnt_next;
    logic          gpio_write_reg, gpio_write_next;
    logic [7:0]    gpio_wdata_reg, gpio_wdata_next;

    mode_t      cur_mode;
    mode_t      load_mode;
    logic       seq_active;
    logic       base_tick;
    logic       step;
    logic       restart;
    logic [2:0] new_ctrl;
    logic [7:0] new_pattern;

    always_comb begin
        cur_mode   = mode_t'(ctrl_reg[1:0]);
        seq_active = ctrl_reg[2] && (cur_mode != MODE_MANUAL);
        base_tick  = seq_active && (presc_reg == PMAX);
        // ">=" rather than "==" so a RATE lowered below the running count
        // still produces a step at the next base tick instead of wrapping.
        step       = base_tick && (rate_cnt_reg >= rate_reg);
        restart    = cpu_write && ((cpu_addr == ADDR_CTRL) || (cpu_addr == ADDR_PATTERN));

        // Register values as they will be after this edge; a restart loads
        // the frame from these, not from the stale contents.
        new_ctrl    = (cpu_write && cpu_addr == ADDR_CTRL)    ? cpu_wdata[2:0] : ctrl_reg;
        new_pattern = (cpu_write && cpu_addr == ADDR_PATTERN) ? cpu_wdata      : pattern_reg;
        load_mode   = mode_t'(new_ctrl[1:0]);

        ctrl_next     = new_ctrl;
        pattern_next  = new_pattern;
        rate_next     = (cpu_write && cpu_addr == ADDR_RATE) ? cpu_wdata : rate_reg;
        frame_next    = frame_reg;
        dir_next      = dir_reg;
        presc_next    = presc_reg;
        rate_cnt_next = rate_cnt_reg;

        if (restart) begin
            // A restart always wins over a coincident step.
            presc_next    = '0;
            rate_cnt_next = '0;
            case (load_mode)
                MODE_MANUAL: frame_next = new_pattern;
                MODE_BLINK:  frame_next = new_pattern;
                MODE_SCAN: begin
                    frame_next = 8'h01;
                    dir_next   = 1'b0;
                end
                MODE_COUNT:  frame_next = 8'h00;
                default:     frame_next = new_pattern;
            endcase
        end else if (!seq_active) begin
            presc_next    = '0;
            rate_cnt_next = '0;
        end else begin
            presc_next = base_tick ? '0 : presc_reg + PW'(1);
            if (base_tick) begin
                rate_cnt_next = step ? 8'd0 : rate_cnt_reg + 8'd1;
            end
            if (step) begin
                case (cur_mode)
                    MODE_BLINK: frame_next = (frame_reg != 8'h00) ? 8'h00 : pattern_reg;
                    MODE_SCAN: begin
                        if (!dir_reg) begin
                            if (frame_reg == 8'h80) begin
                                frame_next = 8'h40;
                                dir_next   = 1'b1;
                            end else begin
                                frame_next = frame_reg << 1;
                            end
                        end else begin
                            if (frame_reg == 8'h01) begin
                                frame_next = 8'h02;
                                dir_next   = 1'b0;
                            end else begin
                                frame_next = frame_reg >> 1;
                            end
                        end
                    end
                    MODE_COUNT: frame_next = frame_reg + 8'd1;
                    default:    frame_next = frame_reg;
                endcase
            end
        end

        gpio_write_next = restart || step;
        gpio_wdata_next = frame_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_reg       <= '0;
            pattern_reg    <= '0;
            rate_reg       <= '0;
            frame_reg      <= '0;
            dir_reg        <= 1'b0;
            presc_reg      <= '0;
            rate_cnt_reg   <= '0;
            gpio_write_reg <= 1'b0;
            gpio_wdata_reg <= '0;
        end else begin
            ctrl_reg       <= ctrl_next;
            pattern_reg    <= pattern_next;
            rate_reg       <= rate_next;
            frame_reg      <= frame_next;
            dir_reg        <= dir_next;
            presc_reg      <= presc_next;
            rate_cnt_reg   <= rate_cnt_next;
            gpio_write_reg <= gpio_write_next;
            gpio_wdata_reg <= gpio_wdata_next;
        end
    end

    always_comb begin
        cpu_rdata = 8'h00;
        if (cpu_read) begin
            case (cpu_addr)
                ADDR_CTRL:    cpu_rdata = {5'b00000, ctrl_reg};
                ADDR_PATTERN: cpu_rdata = pattern_reg;
                ADDR_RATE:    cpu_rdata = rate_reg;
                ADDR_FRAME:   cpu_rdata = frame_reg;
                default:      cpu_rdata = 8'h00;
            endcase
        end
    end

    assign gpio_write = gpio_write_reg;
    assign gpio_wdata = gpio_wdata_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
//
// Directed scenarios followed by a randomized phase. A behavioural model
// tracks the register file, a step countdown (PRESCALE*(RATE+1) cycles from
// each restart) and the displayed frame; each predicted LED write is queued
// with the clock edge it must follow, and an independent monitor matches
// every gpio_write pulse against the queue.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cpu_write = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic [7:0] cpu_wdata = 8'h00;
    logic       cpu_read = 1'b0;
    logic [7:0] cpu_rdata;
    logic       gpio_write;
    logic [7:0] gpio_wdata;

    led_sequencer #(.PRESCALE(P)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_rdata  (cpu_rdata),
        .gpio_write (gpio_write),
        .gpio_wdata (gpio_wdata)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         stamp;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- behavioural model ----------------
    logic [1:0] m_mode = 0;
    logic       m_run = 0;
    logic [7:0] m_pat = 0;
    logic [7:0] m_rate = 0;
    logic [7:0] m_frame = 0;
    logic       m_on = 0;      // blink phase
    int         m_pos = 0;     // scan position 0..13 along 01..80..02
    int         m_cd = 0;      // edges remaining until next step

    function automatic logic [7:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {5'b0, m_run, m_mode};
            2'd1:    return m_pat;
            2'd2:    return m_rate;
            default: return m_frame;
        endcase
    endfunction

    function automatic logic [7:0] scan_value(input int pos);
        int bitn;
        bitn = (pos < 8) ? pos : 14 - pos;
        return 8'(1 << bitn);
    endfunction

    function automatic logic m_running();
        return m_run && (m_mode != 2'd0);
    endfunction

    task automatic push_exp();
        exp_t e;
        e.stamp = edge_cnt + 1;
        e.data  = m_frame;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic w, input logic [1:0] a,
                              input logic [7:0] d, input logic rn);
        if (!rn) begin
            m_mode = 0; m_run = 0; m_pat = 0; m_rate = 0;
            m_frame = 0; m_on = 0; m_pos = 0; m_cd = 0;
            return;
        end
        if (w && a == 2'd0) begin m_mode = d[1:0]; m_run = d[2]; end
        if (w && a == 2'd1) m_pat = d;
        if (w && a == 2'd2) m_rate = d;
        if (w && a < 2'd2) begin
            case (m_mode)
                2'd2:    begin m_pos = 0; m_frame = scan_value(0); end
                2'd3:    m_frame = 8'h00;
                default: begin m_on = 1; m_frame = m_pat; end
            endcase
            m_cd = P * (int'(m_rate) + 1);
            push_exp();
        end else if (m_running()) begin
            m_cd--;
            if (m_cd == 0) begin
                case (m_mode)
                    2'd1: begin m_on = !m_on; m_frame = m_on ? m_pat : 8'h00; end
                    2'd2: begin m_pos = (m_pos + 1) % 14; m_frame = scan_value(m_pos); end
                    default: m_frame = m_frame + 8'd1;
                endcase
                m_cd = P * (int'(m_rate) + 1);
                push_exp();
            end
        end
    endtask

    // One clock of stimulus; optionally checks the combinational read data.
    task automatic cyc(input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic r, input logic rn, input logic chk);
        logic [7:0] want;
        @(negedge clk);
        cpu_write = w; cpu_addr = a; cpu_wdata = d; cpu_read = r; resetn = rn;
        #1;
        if (chk) begin
            want = r ? model_read(a) : 8'h00;
            tests++;
            if (cpu_rdata !== want) begin
                fails++;
                $display("FAIL rdata addr=%0d read=%0b got=%02h want=%02h t=%0t",
                         a, r, cpu_rdata, want, $time);
            end
        end
        model_step(w, a, d, rn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'd0, 8'h00, 0, 1, 0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cyc(1, a, d, 0, 1, 0);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(0, a, 8'h00, 1, 1, 1);
    endtask

    // Idle until the model says the next edge carries a step.
    task automatic wait_step_due(input string name);
        int guard;
        guard = 0;
        while (m_cd != 1 && guard < 3000) begin
            idle(1);
            guard++;
        end
        tests++;
        if (m_cd != 1) begin
            fails++;
            $display("FAIL %s: step never due, countdown=%0d want=1", name, m_cd);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].stamp == edge_cnt) begin
                tests++;
                if (gpio_write !== 1'b1 || gpio_wdata !== exp_q[0].data) begin
                    fails++;
                    $display("FAIL pulse edge=%0d got write=%0b data=%02h want write=1 data=%02h",
                             edge_cnt, gpio_write, gpio_wdata, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else if (gpio_write !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL spurious_pulse edge=%0d got write=%0b data=%02h want write=0",
                         edge_cnt, gpio_write, gpio_wdata);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] a;
        logic [7:0] d;
        int         r;

        // Reset / manual
        for (int i = 0; i < 3; i++) cyc(0, 2'd0, 8'h00, 0, 0, 0);
        idle(4);
        for (int i = 0; i < 4; i++) rd(2'(i));
        cyc(0, 2'd1, 8'h00, 0, 1, 1);           // read strobe low -> 0
        wr(2'd1, 8'hA5);
        idle(2);
        rd(2'd3);

        // Blink
        wr(2'd1, 8'h3C);
        wr(2'd2, 8'h01);
        wr(2'd0, 8'h05);
        idle(34);
        rd(2'd0);

        // Scan
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h06);
        idle(P * 16 + 6);

        // Count through the wrap, then freeze
        wr(2'd0, 8'h07);
        idle(P * 258 + 3);
        rd(2'd3);
        wr(2'd0, 8'h03);
        idle(24);
        rd(2'd3);
        rd(2'd0);

        // Collision: restart into blink on the edge a count step is due
        wr(2'd1, 8'h5A);
        wr(2'd2, 8'h02);
        wr(2'd0, 8'h07);
        idle(P * 3 * 2 + 2);
        wait_step_due("collision");
        wr(2'd0, 8'h05);
        idle(P * 3 * 2 + 4);

        // Reset on the edge a step fires
        wait_step_due("reset_mid");
        cyc(0, 2'd0, 8'h00, 0, 0, 0);
        idle(20);
        for (int i = 0; i < 4; i++) rd(2'(i));

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            if (r < 1) begin
                cyc(0, a, d, 1'($urandom_range(0, 1)), 0, 1);
            end else if (r < 8) begin
                if (a == 2'd2) begin
                    if (m_running()) a = 2'd3;
                    else d = 8'($urandom_range(0, 3));
                end
                cyc(1, a, d, 1'($urandom_range(0, 1)), 1, 1);
            end else begin
                cyc(0, a, d, 1'($urandom_range(0, 1)), 1, ($urandom_range(0, 3) == 0));
            end
        end

        idle(3);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: %0d still queued, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller that owns the write port of the 8-bit system LED GPIO register. Produces a single-cycle write pulse and data for that register.
- A CPU-facing 4-register bus interface selects one of four modes:
  - manual value
  - blink
  - bouncing scan
  - binary count
- Sequenced modes step the LED frame autonomously from a prescaled time base.

Parameters:
- PRESCALE, 50000, clk cycles per base tick; must be >= 1. Counter width is clog2(PRESCALE), minimum 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- resetn  input  1  reset
- cpu_write  input  1  register write strobe, one cycle per access
- cpu_addr  input  2  register select: 0 CTRL, 1 PATTERN, 2 RATE, 3 FRAME (read-only)
- cpu_wdata  input  8  write data
- cpu_read  input  1  read strobe
- cpu_rdata  output  8  read data, combinational; 0 when cpu_read low
- gpio_write  output  1  registered one-cycle write pulse to LED register
- gpio_wdata  output  8  registered data accompanying gpio_write; always equals FRAME

Behaviour:
- Reset (resetn is synchronous, active-low): all registers are cleared.
  - CTRL, PATTERN, RATE, FRAME, direction, prescaler and rate counters = 0.
  - gpio_write = 0, gpio_wdata = 0.
  - No write is issued on reset exit; the LED register resets to 0 independently.
  - Reset asserted mid-sequence aborts any pending pulse in the same edge.
- CTRL register layout:
  - [1:0] mode: 0 manual, 1 blink, 2 scan, 3 count.
  - [2] run.
  - [7:3] read as 0.
- PATTERN, RATE: plain 8-bit read/write registers.
- FRAME: current LED value; CPU writes to address 3 are ignored.
- Read data:
  - cpu_rdata = selected register when cpu_read = 1, else 0.
  - A simultaneous write is visible on cpu_rdata the following cycle.
- Time base:
  - The prescaler counts 0..PRESCALE-1 while run = 1 and mode != 0; the wrap produces a base tick.
  - The rate counter counts base ticks 0..RATE; its wrap produces a step. Step period = PRESCALE*(RATE+1) cycles. RATE = 0 means every base tick.
  - Both counters are held at 0 when run = 0 or mode = 0.
- Step action, applied to FRAME at the step edge:
  - blink: FRAME toggles between PATTERN and 0x00.
  - scan:
    - Direction up: shift left.
    - Direction down: shift right.
    - At FRAME = 0x80 going up: set direction down and FRAME = 0x40. At 0x01 going down: set direction up and FRAME = 0x02.
    - Sequence: 01,02,...,80,40,...,01,02...
  - count: FRAME = FRAME + 1, modulo 256; 0xFF wraps to 0x00.
- Restart: a write to CTRL or PATTERN clears both counters and loads FRAME from the new mode:
  - manual: PATTERN.
  - blink: PATTERN (on phase).
  - scan: 0x01, direction up.
  - count: 0x00.
- A RATE write takes effect at the next rate-counter compare and does not restart.
- Priority: a CPU restart write in the same cycle as a step wins. The step is discarded and the counters restart.
- Output pulse:
  - On every edge where FRAME is loaded or stepped, gpio_write = 1 in the next cycle with gpio_wdata = new FRAME.
  - This gives 1-cycle latency from the cpu_write edge or step edge to the pulse.
  - The pulse is issued even if the value is unchanged (e.g. PATTERN 0 in blink). Pulses never merge; minimum spacing is 1 cycle.
- run = 0 in a sequenced mode: FRAME is frozen and no steps occur. Setting run back to 1 via a CTRL write is a restart (FRAME reloaded).
- Manual mode ignores run. Each PATTERN write updates FRAME immediately and pulses.

Test Plan:
- Reset/manual (PRESCALE=4):
  - Release reset: gpio_write stays 0 and all reads return 0.
  - Write PATTERN=0xA5: next cycle gpio_write=1, gpio_wdata=0xA5. Read addr 3 returns 0xA5.
- Blink: PATTERN=0x3C, RATE=1, CTRL=0x05.
  - Pulse 0x3C immediately.
  - Then pulses 0x00, 0x3C, 0x00 exactly every 8 cycles.
- Scan: CTRL=0x06, RATE=0.
  - Pulse sequence 01,02,04,...,80,40,20,...,01,02, one pulse every 4 cycles.
- Count wrap: CTRL=0x07 and let 256 steps elapse.
  - FRAME progresses 0x00..0xFF, then 0x00 with a pulse.
  - Set run=0 mid-count: no further pulses; FRAME reads stable.
- Collision: issue a CTRL write (mode=blink) on the exact cycle a count step is due.
  - Exactly one pulse, carrying PATTERN, with no count value.
  - Next blink step follows PRESCALE*(RATE+1) cycles later.
- Reset mid-operation: assert resetn=0 on the cycle a step fires.
  - No gpio_write pulse follows.
  - All registers read 0 after release.
